// File: rtl/cpu_pkg.sv
// Shared CPU definitions: CPSR flag positions, condition codes and the flags type.
package cpu_pkg;

   localparam int unsigned FLAG_N   = 31;
   localparam int unsigned FLAG_Z   = 30;
   localparam int unsigned FLAG_C   = 29;
   localparam int unsigned FLAG_V   = 28;
   localparam int unsigned FLAG_LSB = FLAG_V;

   // Positions of each flag inside a packed 4-bit flags word
   localparam int unsigned FI_N = FLAG_N - FLAG_LSB;
   localparam int unsigned FI_Z = FLAG_Z - FLAG_LSB;
   localparam int unsigned FI_C = FLAG_C - FLAG_LSB;
   localparam int unsigned FI_V = FLAG_V - FLAG_LSB;

   typedef logic [3:0] flags_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_t;

endpackage

// File: rtl/cpsr_unit_if.sv
// Flag-producer / condition-consumer bundle between EXE, branch logic and cpsr_unit.
interface cpsr_unit_if;

   logic [31:0] wr_cpsr_val;
   logic        wr_cpsr_en;
   logic [3:0]  cond;
   logic        cond_valid;
   logic        push;
   logic        pop;
   logic [31:0] cpsr;
   logic        take;
   logic        take_valid;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_err;

   modport master (
      output wr_cpsr_val, wr_cpsr_en, cond, cond_valid, push, pop,
      input  cpsr, take, take_valid, stack_full, stack_empty, stack_err
   );

   modport slave (
      input  wr_cpsr_val, wr_cpsr_en, cond, cond_valid, push, pop,
      output cpsr, take, take_valid, stack_full, stack_empty, stack_err
   );

endinterface

// File: rtl/cpsr_unit_cond_eval.sv
// Combinational branch-condition evaluator; shared with decode for static prediction.
module cond_eval
   import cpu_pkg::*;
(
   input  flags_t     flags,
   input  logic [3:0] cond,
   output logic       take
);

   logic n, z, c, v;

   always_comb begin
      n    = flags[FI_N];
      z    = flags[FI_Z];
      c    = flags[FI_C];
      v    = flags[FI_V];
      take = 1'b0;
      case (cond)
         COND_EQ: take = z;
         COND_NE: take = ~z;
         COND_CS: take = c;
         COND_CC: take = ~c;
         COND_MI: take = n;
         COND_PL: take = ~n;
         COND_VS: take = v;
         COND_VC: take = ~v;
         COND_HI: take = c & ~z;
         COND_LS: take = ~c | z;
         COND_GE: take = (n == v);
         COND_LT: take = (n != v);
         COND_GT: take = ~z & (n == v);
         COND_LE: take = z | (n != v);
         COND_AL: take = 1'b1;
         COND_NV: take = 1'b0;
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpsr_unit.sv
// Architectural CPSR flags with forwarded condition evaluation and an
// interrupt save/restore stack of flag words.
module cpsr_unit
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   cpsr_unit_if.slave  cpsr_bus
);

   localparam int unsigned SPW  = $clog2(DEPTH + 1);
   localparam int unsigned IDXW = $clog2(DEPTH);

   flags_t          flags_q, flags_d, ef;
   flags_t          stack_q [DEPTH];
   logic [SPW-1:0]  sp_q, sp_d, sp_m1;
   logic [IDXW-1:0] wr_idx, rd_idx;
   logic            take_q, take_d, take_valid_q;
   logic            full_q, empty_q, err_q, err_d;
   logic            do_push, do_pop, cond_take;
   logic            unused_val_bits;

   assign unused_val_bits = ^cpsr_bus.wr_cpsr_val[FLAG_LSB-1:0];

   // Same-cycle forwarding of a flag write into evaluation and push
   assign ef = cpsr_bus.wr_cpsr_en ? cpsr_bus.wr_cpsr_val[FLAG_N:FLAG_V] : flags_q;

   cond_eval u_cond_eval (
      .flags (ef),
      .cond  (cpsr_bus.cond),
      .take  (cond_take)
   );

   always_comb begin
      do_push = cpsr_bus.push & ~cpsr_bus.pop & ~full_q;
      do_pop  = cpsr_bus.pop & ~cpsr_bus.push & ~empty_q;
      err_d   = (cpsr_bus.push & cpsr_bus.pop) | (cpsr_bus.push & full_q) |
                (cpsr_bus.pop & empty_q);
      sp_m1   = sp_q - SPW'(1);
      wr_idx  = sp_q[IDXW-1:0];
      rd_idx  = sp_m1[IDXW-1:0];

      sp_d = sp_q;
      if (do_push)
         sp_d = sp_q + SPW'(1);
      else if (do_pop)
         sp_d = sp_m1;

      // A legal pop overrides any concurrent flag write
      flags_d = flags_q;
      if (do_pop)
         flags_d = stack_q[rd_idx];
      else if (cpsr_bus.wr_cpsr_en)
         flags_d = cpsr_bus.wr_cpsr_val[FLAG_N:FLAG_V];

      take_d = cpsr_bus.cond_valid ? cond_take : take_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q      <= '0;
         sp_q         <= '0;
         take_q       <= 1'b0;
         take_valid_q <= 1'b0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         flags_q      <= flags_d;
         sp_q         <= sp_d;
         take_q       <= take_d;
         take_valid_q <= cpsr_bus.cond_valid;
         full_q       <= (sp_d == SPW'(DEPTH));
         empty_q      <= (sp_d == '0);
         err_q        <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         stack_q[wr_idx] <= ef;
   end

   assign cpsr_bus.cpsr        = {flags_q, {FLAG_LSB{1'b0}}};
   assign cpsr_bus.take        = take_q;
   assign cpsr_bus.take_valid  = take_valid_q;
   assign cpsr_bus.stack_full  = full_q;
   assign cpsr_bus.stack_empty = empty_q;
   assign cpsr_bus.stack_err   = err_q;

endmodule

// File: tb/tb_cpsr_unit.sv
// Scoreboard bench for cpsr_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cpsr_unit;
   import cpu_pkg::*;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [31:0] cpsr;
      logic        tv;
      logic        tk;
      logic        full;
      logic        empty;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   cpsr_unit_if bus ();

   cpsr_unit #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpsr_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];
   logic take_q[$];
   exp_t e_mon;
   logic t_mon;

   logic [3:0] m_flags;
   logic [3:0] m_stk[$];
   logic       m_take;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Drive one cycle of stimulus and record what the next edge must produce
   task automatic step(input logic we, input logic [31:0] val, input logic [3:0] c,
                       input logic cv, input logic pu, input logic po);
      logic [3:0] ef;
      exp_t       e;
      @(negedge clk);
      bus.wr_cpsr_en  = we;
      bus.wr_cpsr_val = val;
      bus.cond        = c;
      bus.cond_valid  = cv;
      bus.push        = pu;
      bus.pop         = po;
      ef = we ? val[31:28] : m_flags;
      if (cv) begin
         m_take = ref_cond(c, ef);
         take_q.push_back(m_take);
      end
      e.err = (pu && po) || (pu && m_stk.size() == DEPTH) || (po && m_stk.size() == 0);
      if (pu && !po && m_stk.size() < DEPTH)
         m_stk.push_back(ef);
      if (po && !pu && m_stk.size() > 0)
         m_flags = m_stk.pop_back();
      else if (we)
         m_flags = val[31:28];
      e.cpsr  = {m_flags, 28'h0};
      e.tv    = cv;
      e.tk    = m_take;
      e.full  = (m_stk.size() == DEPTH);
      e.empty = (m_stk.size() == 0);
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_cpsr"},  bus.cpsr, 32'h0);
      chk({tag, "_take"},  {31'h0, bus.take}, 32'h0);
      chk({tag, "_tv"},    {31'h0, bus.take_valid}, 32'h0);
      chk({tag, "_full"},  {31'h0, bus.stack_full}, 32'h0);
      chk({tag, "_empty"}, {31'h0, bus.stack_empty}, 32'h1);
      chk({tag, "_err"},   {31'h0, bus.stack_err}, 32'h0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      take_q.delete();
      m_stk.delete();
      m_flags = 4'h0;
      m_take  = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en && exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         chk("cpsr",  bus.cpsr, e_mon.cpsr);
         chk("tv",    {31'h0, bus.take_valid},  {31'h0, e_mon.tv});
         chk("take_hold", {31'h0, bus.take},    {31'h0, e_mon.tk});
         chk("full",  {31'h0, bus.stack_full},  {31'h0, e_mon.full});
         chk("empty", {31'h0, bus.stack_empty}, {31'h0, e_mon.empty});
         chk("err",   {31'h0, bus.stack_err},   {31'h0, e_mon.err});
         if (bus.take_valid) begin
            if (take_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL take_unexpected: got take_valid=1 expected no pending condition");
            end else begin
               t_mon = take_q.pop_front();
               chk("take", {31'h0, bus.take}, {31'h0, t_mon});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.wr_cpsr_en = 1'b0; bus.wr_cpsr_val = '0; bus.cond = '0;
      bus.cond_valid = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
      model_reset();
      #12;
      rst_chk("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Forwarded write feeds the same-cycle condition
      step(1'b1, 32'h4000_0000, COND_EQ, 1'b1, 1'b0, 1'b0);

      // Signed conditions
      step(1'b1, 32'h8000_0000, COND_GE, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, COND_LT, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, COND_LE, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h9000_0000, COND_GT, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, COND_AL, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, COND_NV, 1'b1, 1'b0, 1'b0);
      idle();

      // Save, overwrite, restore; write in the pop cycle is discarded
      step(1'b1, 32'h2000_0000, COND_CS, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h9000_0000, COND_MI, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h5000_0000, COND_MI, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, COND_CS, 1'b1, 1'b0, 1'b0);

      // Overflow then LIFO drain
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b1, {4'(i + 3), 28'h0}, 4'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 32'h0, COND_VS, 1'b1, 1'b0, 1'b1);

      // Underflow with concurrent write, then push/pop conflict
      step(1'b1, 32'hA000_0000, 4'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h6000_0000, COND_NE, 1'b1, 1'b1, 1'b1);
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      idle();

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0));

      // Async reset mid-stream with sp=3 and cpsr=F
      while (m_stk.size() > 0)
         step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, {4'(i + 1), 28'h0}, 4'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'hF000_0000, COND_AL, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      bus.wr_cpsr_en = 1'b0; bus.cond_valid = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
      #1;
      rst_chk("async_rst");
      model_reset();
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      step(1'b0, 32'h0, COND_EQ, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      idle();
      idle();
      @(posedge clk);
      #2;
      checks++;
      if (take_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d take and %0d state entries pending expected 0",
                  take_q.size(), exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
